csa_stream_ctrl: RTL
====================

# csa_stream_ctrl

Sequencer for the CSA stream-cipher byte datapath. It owns the full stream-cipher state register set (A, B, D, E, F, X, Y, Z, p, q, r) and loads it from the common key. It then runs the 8-byte IV initialisation phase and produces keystream bytes one per cycle under a valid/ready handshake. It instantiates exactly one combinational `stream_byte` (4 iterations per evaluation) and feeds its outputs back into the registers each cycle that the state advances.

## Interface
Parameters:
- `LEN_W`, default 8: width of the keystream byte-count request.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `key_load` in 1: one-cycle strobe; loads `ck` into the state. Honoured only in IDLE.
- `ck` in 64: common key.
- `start` in 1: one-cycle strobe; begins IV initialisation and generation. Honoured only in IDLE.
- `iv` in 64: first cipher block. Byte 0 is `iv[63:56]`.
- `ks_len` in LEN_W: number of keystream bytes to produce. Sampled with `start`.
- `ks_data` out 8: keystream byte.
- `ks_valid` out 1: `ks_data` is valid.
- `ks_ready` in 1: consumer accepts `ks_data`.
- `ks_last` out 1: the current byte is the final byte of the request.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last byte is accepted.

## Operation
States: IDLE, INIT, RUN, DRAIN.

**IDLE**
- On `key_load`:
  - A = {8'h00, ck[63:32]}.
  - B = {8'h00, ck[31:0]}.
  - D, E, F, X, Y, Z = 0; p, q, r = 0.
- On `start`:
  - Capture `iv` and `ks_len`.
  - Clear the byte index i, then go to INIT.
  - If `ks_len` = 0, INIT still runs, then go to IDLE with `done` pulsed and no `ks_valid`.
- `key_load` and `start` in the same cycle: the key is loaded first, so `start` uses the new key. Equivalently, the init phase sees the state produced by the key load.

**INIT** (exactly 8 cycles)
- Drive `stream_byte` with init=1 and sb = iv byte i.
- Register its state outputs every cycle; i increments.
- After i = 7, go to RUN.
- Its `op` output is discarded.

**RUN**
- Drive init=0, sb=8'h00.
- The state advances, and `op` is registered into `ks_data` with `ks_valid`=1, only when the output register is empty or being accepted (`ks_valid` & `ks_ready`). Otherwise all state holds.
- A remaining-byte counter is loaded with `ks_len` and decrements on each accepted byte.
- When the byte being loaded is the last one, set `ks_last` with it and go to DRAIN. No further state evaluation happens.

**DRAIN**
- Hold `ks_data`, `ks_valid` and `ks_last` until accepted.
- On acceptance: `ks_valid`=0, `ks_last`=0, pulse `done`, return to IDLE.
- The cipher state is retained, so a later `start` reuses the key state as updated. A new `key_load` gives a fresh key.

**Ignored strobes**
- `key_load` and `start` outside IDLE are ignored.

**Reset**
- Asserting `rst_n` mid-operation aborts immediately to IDLE.
- All state registers, counters and the output register clear to 0.

## Timing
Reset values:
- `ks_data` 0, `ks_valid` 0, `ks_last` 0, `busy` 0, `done` 0.
- State = IDLE; all cipher registers 0.

Latency and throughput:
- `start` sampled at edge T; INIT updates at edges T+1..T+8; first `ks_data` is loaded at edge T+9.
- `ks_valid` is first high after edge T+9.
- `busy` rises after edge T.
- Sustained throughput with `ks_ready`=1 is one byte per cycle.

Handshake rules:
- While `ks_valid`=1 and `ks_ready`=0, `ks_data` and `ks_last` are stable and no cipher state changes.
- `ks_valid` never drops without acceptance.

Other:
- `done` is registered and high for exactly one cycle, the cycle after the last acceptance edge.
- `ks_len` counts modulo 2^LEN_W with no wrap; maximum is 2^LEN_W−1 bytes.

## Structure
Shared package `csa_pkg`:
- State-width constants: A_W=40, B_W=40, NIB_W=4.
- FSM state encoding.
- The key-to-A/B mapping function.

Sub-modules:
- A single instance of `stream_byte`.
- No other sub-module.
- The output register and counters are local.

## Test plan
- Reset mid-RUN with `ks_valid`=1 → all outputs 0 next cycle; `busy`=0; a subsequent `start` without `key_load` starts from the all-zero state.
- Standard vector: key_load, then start with a known IV, `ks_len`=8, `ks_ready`=1.
  - First `ks_valid` 10 cycles after `start`.
  - 8 consecutive bytes match the software model.
  - `ks_last` on byte 8; `done` one cycle after.
- Backpressure: same vector, `ks_ready` toggling pseudo-randomly → identical byte sequence; `ks_data` stable while stalled; no byte lost or duplicated.
- `ks_len`=0 → `busy` for 9 cycles, `done` pulse, `ks_valid` never asserted.
- `start` and `key_load` pulsed during RUN → ignored; output matches the uninterrupted run.
- Same-cycle `key_load`+`start` with key K → output identical to `key_load` K followed later by `start`.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA stream-cipher sequencer: register widths,
// controller state encoding, the packed cipher state, S-box tables and the
// common-key loader.
package csa_pkg;

    localparam int A_W   = 40;
    localparam int B_W   = 40;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

    // Nibble n (1..10) of A/B lives at bits [4n-1:4n-4]; the shift register
    // therefore moves towards the MSB and nibble 10 is the top nibble.
    typedef struct packed {
        logic [A_W-1:0]   a;
        logic [B_W-1:0]   b;
        logic [NIB_W-1:0] d;
        logic [NIB_W-1:0] e;
        logic [NIB_W-1:0] f;
        logic [NIB_W-1:0] x;
        logic [NIB_W-1:0] y;
        logic [NIB_W-1:0] z;
        logic             p;
        logic             q;
        logic             r;
    } cipher_state_t;

    // 5-in/2-out S-boxes, entry 0 in the two MSBs, entry 31 in the two LSBs.
    localparam logic [63:0] SBOX1 = 64'h85BC_E853_3CA5_A35C;
    localparam logic [63:0] SBOX2 = 64'hD2BC_7906_D3E2_069D;
    localparam logic [63:0] SBOX3 = 64'h86BD_53C8_71CA_863D;
    localparam logic [63:0] SBOX4 = 64'hDB26_61C3_4DB3_3869;
    localparam logic [63:0] SBOX5 = 64'h81EE_1F49_B835_4ED2;
    localparam logic [63:0] SBOX6 = 64'h1B68_1CB7_B2C5_963C;
    localparam logic [63:0] SBOX7 = 64'h3AC1_C769_4F16_B4B2;

    function automatic logic [1:0] sbox_lookup(input logic [63:0] tbl, input logic [4:0] idx);
        return tbl[6'd62 - {idx, 1'b0} +: 2];
    endfunction

    // Common key: upper word into A, lower word into B, everything else cleared.
    function automatic cipher_state_t key_to_state(input logic [63:0] ck);
        cipher_state_t s;
        s   = '0;
        s.a = {8'h00, ck[63:32]};
        s.b = {8'h00, ck[31:0]};
        return s;
    endfunction

endpackage

// File: rtl/stream_byte.sv
// Combinational CSA stream-cipher round: four 2-bit iterations that advance
// the cipher state by one byte and produce one output byte.
module stream_byte
    import csa_pkg::*;
(
    input  cipher_state_t cur,
    input  logic          init,
    input  logic [7:0]    sb,
    output cipher_state_t nxt,
    output logic [7:0]    op
);

    typedef struct packed {
        cipher_state_t s;
        logic [1:0]    bits;
    } step_t;

    // One iteration; a_in feeds the A feedback, b_in the B feedback (init only).
    function automatic step_t step(input cipher_state_t s, input logic ini,
                                   input logic [3:0] a_in, input logic [3:0] b_in);
        step_t      o;
        logic [1:0] s1, s2, s3, s4, s5, s6, s7;
        logic [3:0] extra_b, next_a1, next_b1, d_new;
        logic [4:0] sum;

        s1 = sbox_lookup(SBOX1, {s.a[12], s.a[2],  s.a[21], s.a[27], s.a[32]});
        s2 = sbox_lookup(SBOX2, {s.a[5],  s.a[10], s.a[23], s.a[24], s.a[33]});
        s3 = sbox_lookup(SBOX3, {s.a[3],  s.a[4],  s.a[17], s.a[19], s.a[22]});
        s4 = sbox_lookup(SBOX4, {s.a[11], s.a[1],  s.a[7],  s.a[14], s.a[28]});
        s5 = sbox_lookup(SBOX5, {s.a[18], s.a[15], s.a[20], s.a[29], s.a[34]});
        s6 = sbox_lookup(SBOX6, {s.a[9],  s.a[13], s.a[16], s.a[26], s.a[35]});
        s7 = sbox_lookup(SBOX7, {s.a[6],  s.a[8],  s.a[25], s.a[30], s.a[31]});

        extra_b = {s.b[8]  ^ s.b[21] ^ s.b[26] ^ s.b[35],
                   s.b[20] ^ s.b[29] ^ s.b[11] ^ s.b[14],
                   s.b[19] ^ s.b[30] ^ s.b[12] ^ s.b[17],
                   s.b[34] ^ s.b[23] ^ s.b[9]  ^ s.b[28]};

        next_a1 = s.a[39:36] ^ s.x;
        if (ini) next_a1 = next_a1 ^ s.d ^ a_in;
        next_b1 = s.b[27:24] ^ s.b[39:36] ^ s.y;
        if (ini) next_b1 = next_b1 ^ b_in;
        if (s.p) next_b1 = {next_b1[2:0], next_b1[3]};

        d_new = s.e ^ s.z ^ extra_b;
        sum   = {1'b0, s.z} + {1'b0, s.e} + {4'b0000, s.r};

        o.s   = s;
        o.s.d = d_new;
        o.s.e = s.f;
        if (s.q) begin
            o.s.f = sum[3:0];
            o.s.r = sum[4];
        end else begin
            o.s.f = s.e;
        end
        o.s.a  = {s.a[A_W-5:0], next_a1};
        o.s.b  = {s.b[B_W-5:0], next_b1};
        o.s.x  = {s4[0], s3[0], s2[1], s1[1]};
        o.s.y  = {s6[0], s5[0], s4[1], s3[1]};
        o.s.z  = {s2[0], s1[0], s6[1], s5[1]};
        o.s.p  = s7[1];
        o.s.q  = s7[0];
        o.bits = {d_new[3] ^ d_new[2], d_new[1] ^ d_new[0]};
        return o;
    endfunction

    cipher_state_t s_work;
    step_t         r_work;

    // Chain four iterations; the high nibble of sb drives A on even iterations.
    always_comb begin
        // NOTE: outputs and working variables get a value before any branch, and
        // blocking '=' is used here so each iteration sees the previous result.
        s_work = cur;
        r_work = '0;
        op     = '0;
        for (int j = 0; j < 4; j++) begin
            if (j % 2 == 0) r_work = step(s_work, init, sb[7:4], sb[3:0]);
            else            r_work = step(s_work, init, sb[3:0], sb[7:4]);
            s_work = r_work.s;
            op     = {op[5:0], r_work.bits};
        end
        nxt = s_work;
    end

endmodule

// File: rtl/csa_stream_ctrl.sv
// CSA stream-cipher sequencer: key load, 8-byte IV initialisation, then a
// keystream byte per cycle behind a valid/ready output register.
module csa_stream_ctrl
    import csa_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic [63:0]      ck,
    input  logic             start,
    input  logic [63:0]      iv,
    input  logic [LEN_W-1:0] ks_len,
    output logic [7:0]       ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last,
    output logic             busy,
    output logic             done
);

    ctrl_state_e      state_q, state_d;
    cipher_state_t    cs_q, cs_next;
    logic [63:0]      iv_q;       // shifts left so the current IV byte is on top
    logic [2:0]       idx_q;
    logic [LEN_W-1:0] left_q;     // bytes still to be generated
    logic             sb_init;
    logic [7:0]       sb_in;
    logic [7:0]       sb_op;
    logic             load_byte;

    assign sb_init = (state_q == ST_INIT);
    assign sb_in   = sb_init ? iv_q[63:56] : 8'h00;
    assign busy    = (state_q != ST_IDLE);

    stream_byte u_stream_byte (
        .cur  (cs_q),
        .init (sb_init),
        .sb   (sb_in),
        .nxt  (cs_next),
        .op   (sb_op)
    );

    // Next state and the "evaluate a keystream byte this cycle" decision.
    always_comb begin
        state_d   = state_q;
        load_byte = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT:  if (idx_q == 3'd7) state_d = ST_RUN;
            ST_RUN: begin
                if (left_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!ks_valid || ks_ready) begin
                    load_byte = 1'b1;
                    if (left_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (ks_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Cipher state, IV shifter, counters and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q     <= '0;
            iv_q     <= '0;
            idx_q    <= '0;
            left_q   <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
            ks_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (key_load) cs_q <= key_to_state(ck);
                    if (start) begin
                        iv_q   <= iv;
                        left_q <= ks_len;
                        idx_q  <= '0;
                    end
                end
                ST_INIT: begin
                    cs_q  <= cs_next;
                    iv_q  <= {iv_q[55:0], 8'h00};
                    idx_q <= idx_q + 3'd1;
                end
                ST_RUN: begin
                    if (left_q == '0) begin
                        done <= 1'b1;
                    end else if (load_byte) begin
                        cs_q     <= cs_next;
                        ks_data  <= sb_op;
                        ks_valid <= 1'b1;
                        ks_last  <= (left_q == LEN_W'(1));
                        left_q   <= left_q - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (ks_ready) begin
                        ks_valid <= 1'b0;
                        ks_last  <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
